// File: rtl/cam_frame_packer.sv
// cam_frame_packer
// ----------------
// Camera capture front end. Collects DATA_W-bit camera bytes into WORD_W-bit
// memory words, presents them with a DDR write address on a valid/ready
// handshake, and rotates successive good frames across NUM_BUFS frame
// buffers. Each frame is validated: dropped words (backpressure overflow),
// short frames, long frames and partial trailing words all flag frame_err.
//
// Ports
//   p_clk       camera pixel clock, all logic on its rising edge
//   rst_n       synchronous active-low reset
//   data        camera byte
//   href        line valid, data is sampled while high
//   vsync       frame sync, high during blanking
//   enable      capture enable, only looked at when a frame is about to start
//   wr_data     packed memory word
//   wr_valid    wr_data/wr_address are valid
//   wr_ready    downstream accepts the current word
//   wr_address  word address in DDR
//   frame_done  one-cycle pulse when a captured frame has fully drained
//   frame_err   qualifies frame_done: the frame was bad
//   frame_buf   index of the last good completed buffer
//   capturing   high while a frame is being captured or drained
module cam_frame_packer #(
  parameter int DATA_W      = 8,
  parameter int WORD_W      = 128,
  parameter int ADDR_W      = 25,
  parameter int ADDR_STEP   = 4,
  parameter int FRAME_WORDS = 38400,
  parameter int NUM_BUFS    = 2,
  parameter int MSB_FIRST   = 0
) (
  input  logic              p_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              href,
  input  logic              vsync,
  input  logic              enable,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_address,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        frame_buf,
  output logic              capturing
);

  localparam int BYTES = WORD_W / DATA_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  // Word index has room for FRAME_WORDS+1 so that "too many words" stays
  // distinguishable from "exactly right" once it saturates.
  localparam int IDX_W = $clog2(FRAME_WORDS + 2);

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]  FRAME_IDX = IDX_W'(FRAME_WORDS);
  localparam logic [IDX_W-1:0]  IDX_SAT   = IDX_W'(FRAME_WORDS + 1);
  localparam logic [ADDR_W-1:0] BUF_SPAN  = ADDR_W'(FRAME_WORDS * ADDR_STEP);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [1:0]        LAST_BUF  = 2'(NUM_BUFS - 1);

  typedef enum logic [1:0] {
    S_SYNC,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cur_buf_q, cur_buf_d;
  logic [1:0]        frame_buf_q, frame_buf_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_address_q, wr_address_d;
  logic              wr_valid_q, wr_valid_d;

  logic              pending;
  logic              frame_done_c;
  logic              bad_c;
  logic [CNT_W-1:0]  lane;
  logic [WORD_W-1:0] byte_word;

  always_ff @(posedge p_clk) begin
    if (!rst_n) begin
      state_q      <= S_SYNC;
      cur_buf_q    <= '0;
      frame_buf_q  <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      err_q        <= 1'b0;
      base_q       <= '0;
      asm_q        <= '0;
      wr_data_q    <= '0;
      wr_address_q <= '0;
      wr_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_buf_q    <= cur_buf_d;
      frame_buf_q  <= frame_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      err_q        <= err_d;
      base_q       <= base_d;
      asm_q        <= asm_d;
      wr_data_q    <= wr_data_d;
      wr_address_q <= wr_address_d;
      wr_valid_q   <= wr_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_buf_d    = cur_buf_q;
    frame_buf_d  = frame_buf_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    err_d        = err_q;
    base_d       = base_q;
    asm_d        = asm_q;
    wr_data_d    = wr_data_q;
    wr_address_d = wr_address_q;
    frame_done_c = 1'b0;

    // A word still waiting for the arbiter. An acceptance this cycle frees
    // the slot, so a word completing now is presented rather than dropped.
    pending    = wr_valid_q & ~wr_ready;
    wr_valid_d = pending;

    bad_c = err_q | (word_idx_q != FRAME_IDX) | (byte_cnt_q != '0);

    lane = (MSB_FIRST != 0) ? (LAST_BYTE - byte_cnt_q) : byte_cnt_q;

    // Current assembly word with this cycle's byte merged in; on the last
    // byte of a word this is the complete word to hand downstream.
    byte_word = asm_q;
    for (int i = 0; i < BYTES; i++) begin
      if (lane == CNT_W'(i)) begin
        byte_word[i*DATA_W +: DATA_W] = data;
      end
    end

    case (state_q)
      S_SYNC: begin
        // Never join a frame mid-way: wait for blanking first.
        if (vsync) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!vsync && enable) begin
          state_d    = S_CAPTURE;
          byte_cnt_d = '0;
          word_idx_d = '0;
          err_d      = 1'b0;
          base_d     = ADDR_W'(cur_buf_q) * BUF_SPAN;
        end
      end

      S_CAPTURE: begin
        if (href) begin
          asm_d = byte_word;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (word_idx_q >= FRAME_IDX) begin
              err_d = 1'b1;
            end else if (pending) begin
              err_d = 1'b1;
            end else begin
              wr_valid_d   = 1'b1;
              wr_data_d    = byte_word;
              wr_address_d = base_q + ADDR_W'(word_idx_q) * STEP;
            end
            // Dropped words still consume an address slot so later words
            // land where they belong.
            if (word_idx_q != IDX_SAT) begin
              word_idx_d = word_idx_q + IDX_W'(1);
            end
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
        if (vsync) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (!wr_valid_q) begin
          frame_done_c = 1'b1;
          state_d      = S_ARMED;
          // A bad frame keeps the same buffer so it is overwritten next time.
          if (!bad_c) begin
            frame_buf_d = cur_buf_q;
            cur_buf_d   = (cur_buf_q == LAST_BUF) ? 2'd0 : cur_buf_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  assign wr_data    = wr_data_q;
  assign wr_address = wr_address_q;
  assign wr_valid   = wr_valid_q;
  assign frame_done = frame_done_c;
  assign frame_err  = frame_done_c & bad_c;
  // Show the buffer just completed alongside its frame_done pulse.
  assign frame_buf  = (frame_done_c && !bad_c) ? cur_buf_q : frame_buf_q;
  assign capturing  = (state_q == S_CAPTURE) || (state_q == S_DRAIN);

endmodule
